spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 149 ++++++++++++++
 tb/tb_spi_master.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI-style command master: sends an 11-bit command frame MSB first and,
// for the read command, waits a turnaround gap and then shifts in one byte
// from MISO. Every output is a flop, updated in the same block as the state.
//
// Handshake: start is a request-only strobe and is looked at only in IDLE.
// While busy=1 both start and tx_frame are ignored. A transfer always ends
// with exactly one done pulse, shown in the END cycle. rd_valid pulses in
// that same cycle only when all 8 read bits were captured.
module spi_master #(
  parameter int       TURNAROUND = 2,
  parameter logic [2:0] RD_CMD   = 3'b111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [10:0] tx_frame,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        SS_n,
  output logic        MOSI,
  input  logic        MISO,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    WAIT  = 3'd3,
    RECV  = 3'd4,
    END   = 3'd5
  } state_t;

  // Last value of the wait counter before moving on to RECV.
  localparam logic [3:0] WAIT_LAST = (TURNAROUND == 0) ? 4'd0 : 4'(TURNAROUND - 1);

  state_t      state;
  logic [10:0] sh;
  logic        is_rd;
  logic [3:0]  bit_cnt;
  logic [3:0]  wait_cnt;

  assign state_dbg = state;

  // Transfer sequencer with registered outputs. The shift register sends
  // the frame out of bit 10 and is then reused to collect the MISO bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sh       <= '0;
      is_rd    <= 1'b0;
      bit_cnt  <= '0;
      wait_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      if (abort && (state == LEAD || state == SHIFT || state == WAIT || state == RECV)) begin
        // Cancel: close the frame, keep rd_data, no rd_valid.
        state    <= END;
        SS_n     <= 1'b1;
        MOSI     <= 1'b0;
        done     <= 1'b1;
        bit_cnt  <= '0;
        wait_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              sh    <= tx_frame;
              is_rd <= (tx_frame[10:8] == RD_CMD);
              state <= LEAD;
              busy  <= 1'b1;
              SS_n  <= 1'b0;
              MOSI  <= 1'b0;
            end
          end
          LEAD: begin
            state   <= SHIFT;
            MOSI    <= sh[10];
            sh      <= {sh[9:0], 1'b0};
            bit_cnt <= '0;
          end
          SHIFT: begin
            if (bit_cnt == 4'd10) begin
              bit_cnt <= '0;
              MOSI    <= 1'b0;
              if (!is_rd) begin
                state <= END;
                SS_n  <= 1'b1;
                done  <= 1'b1;
              end else if (TURNAROUND == 0) begin
                state <= RECV;
              end else begin
                state <= WAIT;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              MOSI    <= sh[10];
              sh      <= {sh[9:0], 1'b0};
            end
          end
          WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
              wait_cnt <= '0;
              state    <= RECV;
            end else begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end
          RECV: begin
            sh <= {sh[9:0], MISO};
            if (bit_cnt == 4'd7) begin
              bit_cnt  <= '0;
              rd_data  <= {sh[6:0], MISO};
              rd_valid <= 1'b1;
              done     <= 1'b1;
              SS_n     <= 1'b1;
              state    <= END;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          END: begin
            state <= IDLE;
            busy  <= 1'b0;
            SS_n  <= 1'b1;
            MOSI  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            SS_n  <= 1'b1;
            MOSI  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: write frame, read frame with default and
// zero turnaround, abort during RECV, async reset mid-frame, back-to-back.
module tb_spi_master;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [10:0] tx_frame;
  logic        miso;
  logic        sel;

  logic        busy_a, done_a, rd_valid_a, ss_n_a, mosi_a;
  logic [7:0]  rd_data_a;
  logic [2:0]  state_a;
  logic        busy_b, done_b, rd_valid_b, ss_n_b, mosi_b;
  logic [7:0]  rd_data_b;
  logic [2:0]  state_b;

  logic        start_a, start_b, abort_a, abort_b;
  logic        v_busy, v_done, v_rd_valid, v_ss_n, v_mosi;
  logic [7:0]  v_rd_data;

  int checks;
  int failures;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign abort_a = abort & ~sel;
  assign abort_b = abort & sel;

  assign v_busy     = sel ? busy_b     : busy_a;
  assign v_done     = sel ? done_b     : done_a;
  assign v_rd_valid = sel ? rd_valid_b : rd_valid_a;
  assign v_ss_n     = sel ? ss_n_b     : ss_n_a;
  assign v_mosi     = sel ? mosi_b     : mosi_a;
  assign v_rd_data  = sel ? rd_data_b  : rd_data_a;

  spi_master dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .tx_frame(tx_frame), .busy(busy_a), .done(done_a), .rd_data(rd_data_a),
    .rd_valid(rd_valid_a), .SS_n(ss_n_a), .MOSI(mosi_a), .MISO(miso),
    .state_dbg(state_a)
  );

  spi_master #(.TURNAROUND(0)) dut_t0 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .tx_frame(tx_frame), .busy(busy_b), .done(done_b), .rd_data(rd_data_b),
    .rd_valid(rd_valid_b), .SS_n(ss_n_b), .MOSI(mosi_b), .MISO(miso),
    .state_dbg(state_b)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transfer; samples at negedge, MISO/abort driven at negedge.
  task automatic run_xfer(input logic s, input logic [10:0] frame, input logic [7:0] mbyte,
                          input int trn, input int abort_at, input int exp_low,
                          input logic [11:0] exp_mosi, input logic exp_valid,
                          input logic [7:0] exp_data, input string tag);
    int low;
    int idx;
    logic [11:0] mv;
    logic tail;
    sel = s;
    @(negedge clk);
    tx_frame = frame;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tx_frame = ~frame;
    low = 0;
    mv = '0;
    tail = 1'b0;
    while (v_ss_n == 1'b0 && low < 40) begin
      if (low < 12) mv = {mv[10:0], v_mosi};
      else tail = tail | v_mosi;
      if (low == 3) check({tag, " busy_mid"}, 32'(v_busy), 32'd1);
      idx = low - 12 - trn;
      miso = (idx >= 0 && idx < 8) ? mbyte[7 - idx] : 1'b0;
      abort = (low == abort_at);
      low++;
      @(negedge clk);
    end
    abort = 1'b0;
    miso = 1'b0;
    check({tag, " ss_low_cycles"}, 32'(low), 32'(exp_low));
    check({tag, " mosi_bits"}, 32'(mv), 32'(exp_mosi));
    check({tag, " mosi_tail"}, 32'(tail), 32'd0);
    check({tag, " end_done"}, 32'(v_done), 32'd1);
    check({tag, " end_rd_valid"}, 32'(v_rd_valid), 32'(exp_valid));
    check({tag, " end_rd_data"}, 32'(v_rd_data), 32'(exp_data));
    check({tag, " end_busy"}, 32'(v_busy), 32'd1);
    @(negedge clk);
    check({tag, " idle_done"}, 32'(v_done), 32'd0);
    check({tag, " idle_busy"}, 32'(v_busy), 32'd0);
    check({tag, " idle_ss_n"}, 32'(v_ss_n), 32'd1);
    check({tag, " idle_rd_valid"}, 32'(v_rd_valid), 32'd0);
  endtask

  // Directed sequence
  initial begin
    int lo1, hi, lo2, dones, ph;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tx_frame = '0;
    miso = 1'b0;
    sel = 1'b0;
    #23;
    check("rst ss_n", 32'(ss_n_a), 32'd1);
    check("rst mosi", 32'(mosi_a), 32'd0);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst done", 32'(done_a), 32'd0);
    check("rst rd_valid", 32'(rd_valid_a), 32'd0);
    check("rst rd_data", 32'(rd_data_a), 32'h00);
    check("rst state", 32'(state_a), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    run_xfer(1'b0, 11'b000_1010_0101, 8'h00, 2, -1, 12, 12'h0A5, 1'b0, 8'h00, "write");
    run_xfer(1'b0, 11'b111_0000_0000, 8'hCA, 2, -1, 22, 12'h700, 1'b1, 8'hCA, "read");
    run_xfer(1'b1, 11'b111_0000_0000, 8'h5A, 0, -1, 20, 12'h700, 1'b1, 8'h5A, "read_t0");
    // Abort raised in the 3rd RECV cycle (LEAD + 11 SHIFT + 2 WAIT + 2 RECV).
    run_xfer(1'b0, 11'b111_0000_0000, 8'hFF, 2, 16, 17, 12'h700, 1'b0, 8'hCA, "abort_recv");

    sel = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    check("abort_idle busy", 32'(busy_a), 32'd0);
    check("abort_idle done", 32'(done_a), 32'd0);
    abort = 1'b0;

    // Asynchronous reset in the middle of SHIFT, away from any clock edge.
    @(negedge clk);
    tx_frame = 11'b000_1010_0101;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst ss_n", 32'(ss_n_a), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst ss_n", 32'(ss_n_a), 32'd1);
    check("async_rst busy", 32'(busy_a), 32'd0);
    check("async_rst done", 32'(done_a), 32'd0);
    check("async_rst rd_data", 32'(rd_data_a), 32'h00);
    check("async_rst state", 32'(state_a), 32'd0);
    @(negedge clk);
    check("held_rst done", 32'(done_a), 32'd0);
    #2 rst_n = 1'b1;
    run_xfer(1'b0, 11'b001_1111_0000, 8'h00, 2, -1, 12, 12'h1F0, 1'b0, 8'h00, "post_rst");

    // Back-to-back: start held high, SS_n gap must be exactly END + IDLE.
    sel = 1'b0;
    @(negedge clk);
    tx_frame = 11'b000_1010_0101;
    start = 1'b1;
    lo1 = 0; hi = 0; lo2 = 0; dones = 0; ph = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done_a) dones++;
      case (ph)
        0: if (!ss_n_a) begin lo1++; ph = 1; end
        1: if (!ss_n_a) lo1++; else begin hi++; ph = 2; end
        2: if (ss_n_a) hi++; else begin lo2++; ph = 3; end
        3: if (!ss_n_a) lo2++; else ph = 4;
        default: ;
      endcase
    end
    start = 1'b0;
    check("b2b first_low", 32'(lo1), 32'd12);
    check("b2b gap_high", 32'(hi), 32'd2);
    check("b2b second_low", 32'(lo2), 32'd12);
    check("b2b done_count", 32'(dones), 32'd2);
    repeat (30) @(negedge clk);
    check("b2b final_busy", 32'(busy_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
